// File: rtl/hist_cdf_builder_pkg.sv
// Shared image-processing constants and the histogram/CDF builder state encoding.
package hist_cdf_builder_pkg;

  localparam int unsigned DW_DEF = 8;
  localparam int unsigned TW_DEF = 32;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    DRAIN,
    SWEEP,
    SWAP
  } state_e;

  // Minimum vertical blanking (cycles) for a 2^dw-bin sweep to finish before the next frame.
  function automatic int unsigned blank_cycles(input int unsigned dw);
    return (32'd1 << dw) + 32'd4;
  endfunction

  localparam int unsigned BLANK_MIN = blank_cycles(DW_DEF);

endpackage

// File: rtl/hist_dpram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset on contents.
module hist_dpram #(
  parameter int unsigned AW = 8,
  parameter int unsigned WW = 32
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [WW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [WW-1:0] rdata_o
);

  logic [WW-1:0] mem_q [2**AW];
  logic [WW-1:0] rdata_q;

  // Write and read-before-write registered read.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/hist_cdf_builder.sv
// Per-frame histogram collection, CDF sweep into a shadow bank, and bank swap on completion.
module hist_cdf_builder
  import hist_cdf_builder_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned IW = 640,
  parameter int unsigned IH = 512,
  parameter int unsigned TW = TW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          din_valid,
  input  logic [DW-1:0] din,
  input  logic          vsync,
  input  logic [DW-1:0] rd_addr,
  output logic [TW-1:0] rd_data,
  output logic          cdf_valid,
  output logic          cdf_done,
  output logic [TW-1:0] total,
  output logic          size_err,
  output logic          overrun
);

  localparam int unsigned NB        = 1 << DW;
  localparam logic [DW:0] SW_END    = (DW+1)'(NB);
  localparam logic [TW-1:0] FRAME_PIX = TW'(IW * IH);

  state_e        state_q;
  logic          vs_q, rise, fall;
  logic          clr_busy_q;
  logic [DW-1:0] clr_idx_q;
  logic          pend_q, dr_q;
  logic [DW:0]   sw_idx_q;
  logic          sw_v_q;
  logic [DW-1:0] sw_a_q;
  logic          p1_v_q, lw_v_q;
  logic [DW-1:0] p1_a_q, lw_a_q;
  logic [TW-1:0] lw_d_q, sum_q;
  logic          bank_sel_q, rd_sel_q, rd_ok_q;
  logic          cdf_valid_q, cdf_done_q, size_err_q, overrun_q;
  logic [TW-1:0] total_q;

  logic          accept, sweep_rd, busy_overlap, go_collect;
  logic [TW-1:0] cnt_rdata, cnt_base, cnt_inc_d, sum_d;
  logic [TW:0]   sum_ext;
  logic          cnt_we;
  logic [DW-1:0] cnt_waddr, cnt_raddr;
  logic [TW-1:0] cnt_wdata;
  logic [TW-1:0] cdf0_rdata, cdf1_rdata;

  assign rise         = vsync & ~vs_q;
  assign fall         = ~vsync & vs_q;
  assign accept       = (state_q == COLLECT) && din_valid;
  assign sweep_rd     = (state_q == SWEEP) && !sw_idx_q[DW];
  assign busy_overlap = (state_q == DRAIN) || (state_q == SWEEP) || (state_q == SWAP) ||
                        ((state_q == IDLE) && clr_busy_q);
  assign go_collect   = vsync && (pend_q || rise);

  // A pixel one cycle behind on the same bin read stale RAM data; take the pending write instead.
  assign cnt_base  = (lw_v_q && (lw_a_q == p1_a_q)) ? lw_d_q : cnt_rdata;
  assign cnt_inc_d = (&cnt_base) ? cnt_base : cnt_base + 1'b1;
  assign sum_ext   = {1'b0, sum_q} + {1'b0, cnt_rdata};
  assign sum_d     = sum_ext[TW] ? '1 : sum_ext[TW-1:0];

  // Count RAM port steering: initial clear, sweep read-and-clear, or pixel increment.
  always_comb begin
    cnt_we    = 1'b0;
    cnt_waddr = '0;
    cnt_wdata = '0;
    cnt_raddr = din;
    if ((state_q == IDLE) && clr_busy_q) begin
      cnt_we    = 1'b1;
      cnt_waddr = clr_idx_q;
    end
    if (sweep_rd) begin
      cnt_raddr = sw_idx_q[DW-1:0];
      cnt_we    = 1'b1;
      cnt_waddr = sw_idx_q[DW-1:0];
    end
    if (p1_v_q) begin
      cnt_we    = 1'b1;
      cnt_waddr = p1_a_q;
      cnt_wdata = cnt_inc_d;
    end
  end

  // Control FSM with pixel pipeline, sweep accumulator and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      vs_q        <= 1'b0;
      clr_busy_q  <= 1'b1;
      clr_idx_q   <= '0;
      pend_q      <= 1'b0;
      dr_q        <= 1'b0;
      sw_idx_q    <= '0;
      sw_v_q      <= 1'b0;
      sw_a_q      <= '0;
      p1_v_q      <= 1'b0;
      p1_a_q      <= '0;
      lw_v_q      <= 1'b0;
      lw_a_q      <= '0;
      lw_d_q      <= '0;
      sum_q       <= '0;
      bank_sel_q  <= 1'b0;
      rd_sel_q    <= 1'b0;
      rd_ok_q     <= 1'b0;
      cdf_valid_q <= 1'b0;
      cdf_done_q  <= 1'b0;
      total_q     <= '0;
      size_err_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      vs_q       <= vsync;
      cdf_done_q <= 1'b0;
      p1_v_q     <= accept;
      p1_a_q     <= din;
      lw_v_q     <= p1_v_q;
      lw_a_q     <= p1_a_q;
      lw_d_q     <= cnt_inc_d;
      sw_v_q     <= sweep_rd;
      sw_a_q     <= sw_idx_q[DW-1:0];
      rd_sel_q   <= bank_sel_q;
      rd_ok_q    <= cdf_valid_q;
      if (sw_v_q) sum_q <= sum_d;
      if (rise && busy_overlap) begin
        pend_q    <= 1'b1;
        overrun_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (clr_busy_q) begin
            clr_idx_q <= clr_idx_q + 1'b1;
            if (&clr_idx_q) begin
              clr_busy_q <= 1'b0;
              pend_q     <= 1'b0;
              if (go_collect) state_q <= COLLECT;
            end
          end else if (rise) begin
            state_q <= COLLECT;
          end
        end
        COLLECT: begin
          if (fall) begin
            state_q <= DRAIN;
            dr_q    <= 1'b0;
          end
        end
        DRAIN: begin
          dr_q <= 1'b1;
          if (dr_q) begin
            state_q  <= SWEEP;
            sw_idx_q <= '0;
          end
        end
        SWEEP: begin
          sw_idx_q <= sw_idx_q + 1'b1;
          if (sw_idx_q == SW_END) state_q <= SWAP;
        end
        SWAP: begin
          bank_sel_q  <= ~bank_sel_q;
          total_q     <= sum_q;
          cdf_done_q  <= 1'b1;
          cdf_valid_q <= 1'b1;
          if (sum_q != FRAME_PIX) size_err_q <= 1'b1;
          sum_q       <= '0;
          pend_q      <= 1'b0;
          state_q     <= go_collect ? COLLECT : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  hist_dpram #(.AW(DW), .WW(TW)) u_cnt (
    .clk(clk), .we_i(cnt_we), .waddr_i(cnt_waddr), .wdata_i(cnt_wdata),
    .raddr_i(cnt_raddr), .rdata_o(cnt_rdata)
  );

  hist_dpram #(.AW(DW), .WW(TW)) u_cdf0 (
    .clk(clk), .we_i(sw_v_q && bank_sel_q), .waddr_i(sw_a_q), .wdata_i(sum_d),
    .raddr_i(rd_addr), .rdata_o(cdf0_rdata)
  );

  hist_dpram #(.AW(DW), .WW(TW)) u_cdf1 (
    .clk(clk), .we_i(sw_v_q && !bank_sel_q), .waddr_i(sw_a_q), .wdata_i(sum_d),
    .raddr_i(rd_addr), .rdata_o(cdf1_rdata)
  );

  // Bank select and validity are delayed to line up with the registered RAM read.
  assign rd_data   = rd_ok_q ? (rd_sel_q ? cdf1_rdata : cdf0_rdata) : '0;
  assign cdf_valid = cdf_valid_q;
  assign cdf_done  = cdf_done_q;
  assign total     = total_q;
  assign size_err  = size_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_hist_cdf_builder.sv
// Directed, table-driven bench for hist_cdf_builder (DW=8, IW=4, IH=2, TW=32).
module tb_hist_cdf_builder;

  logic        clk = 1'b0;
  logic        rst_n, din_valid, vsync;
  logic [7:0]  din, rd_addr;
  logic [31:0] rd_data, total;
  logic        cdf_valid, cdf_done, size_err, overrun;

  always #5 clk = ~clk;

  hist_cdf_builder #(.DW(8), .IW(4), .IH(2), .TW(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din), .vsync(vsync),
    .rd_addr(rd_addr), .rd_data(rd_data), .cdf_valid(cdf_valid), .cdf_done(cdf_done),
    .total(total), .size_err(size_err), .overrun(overrun)
  );

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] exp;
  } vec_t;
  typedef logic [7:0] pq_t[$];

  int checks = 0;
  int errors = 0;
  int mon_bad;
  bit ok;

  vec_t tbl_a[$], tbl_b[$], tbl_d[$], tbl_e[$], tbl_f[$];
  pq_t  px_a, px_b, px_c, px_d, px_f;

  function automatic vec_t mk(input logic [7:0] a, input logic [31:0] e);
    vec_t v;
    v.addr = a;
    v.exp  = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input pq_t px, input bit gaps);
    @(posedge clk);
    #1 vsync = 1'b1;
    tick(2);
    foreach (px[i]) begin
      din = px[i];
      din_valid = 1'b1;
      tick(1);
      if (gaps) begin
        din_valid = 1'b0;
        tick(1);
      end
    end
    din_valid = 1'b0;
    tick(2);
    vsync = 1'b0;
  endtask

  task automatic wait_done(input bit mon, input logic [31:0] oldv, output bit seen);
    seen = 1'b0;
    mon_bad = 0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (cdf_done) begin
        seen = 1'b1;
        break;
      end
      if (mon && rd_data !== oldv) mon_bad++;
    end
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] e, input string name);
    @(posedge clk);
    #1 rd_addr = a;
    @(posedge clk);
    @(negedge clk);
    chk(name, rd_data, e);
  endtask

  task automatic run_tbl(input string tag, input vec_t t[$]);
    foreach (t[i]) rd(t[i].addr, t[i].exp, $sformatf("%s_cdf%0d", tag, t[i].addr));
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_rd_data"}, rd_data, 0);
    chk({tag, "_cdf_valid"}, {31'd0, cdf_valid}, 0);
    chk({tag, "_cdf_done"}, {31'd0, cdf_done}, 0);
    chk({tag, "_total"}, total, 0);
    chk({tag, "_size_err"}, {31'd0, size_err}, 0);
    chk({tag, "_overrun"}, {31'd0, overrun}, 0);
  endtask

  initial begin
    px_a = '{8'd3, 8'd3, 8'd3, 8'd3, 8'd7, 8'd7, 8'd0, 8'd255};
    px_b = '{8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10};
    px_c = '{8'd3, 8'd3, 8'd3, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200};
    px_d = '{8'd1, 8'd1, 8'd2, 8'd2, 8'd2, 8'd5};
    px_f = '{8'd4, 8'd4, 8'd4, 8'd4, 8'd4, 8'd4, 8'd4, 8'd4};
    tbl_a.push_back(mk(0, 1));   tbl_a.push_back(mk(2, 1));   tbl_a.push_back(mk(3, 5));
    tbl_a.push_back(mk(6, 5));   tbl_a.push_back(mk(7, 7));   tbl_a.push_back(mk(254, 7));
    tbl_a.push_back(mk(255, 8));
    tbl_b.push_back(mk(3, 0));   tbl_b.push_back(mk(9, 0));   tbl_b.push_back(mk(10, 8));
    tbl_b.push_back(mk(255, 8));
    tbl_d.push_back(mk(0, 0));   tbl_d.push_back(mk(1, 2));   tbl_d.push_back(mk(2, 5));
    tbl_d.push_back(mk(4, 5));   tbl_d.push_back(mk(5, 6));   tbl_d.push_back(mk(255, 6));
    tbl_e.push_back(mk(0, 1));   tbl_e.push_back(mk(3, 5));   tbl_e.push_back(mk(7, 7));
    tbl_e.push_back(mk(9, 7));   tbl_e.push_back(mk(255, 8));
    tbl_f.push_back(mk(3, 0));   tbl_f.push_back(mk(4, 8));   tbl_f.push_back(mk(9, 8));
    tbl_f.push_back(mk(50, 8));  tbl_f.push_back(mk(255, 8));

    rst_n = 1'b0; vsync = 1'b0; din_valid = 1'b0; din = '0; rd_addr = '0;
    repeat (3) @(negedge clk);
    chk_reset_outs("rst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick(270);
    rd(8'd3, 0, "pre_rd_data");
    chk("pre_cdf_valid", {31'd0, cdf_valid}, 0);

    // Frame A: back-to-back pixels including a run of four equal bins.
    send_frame(px_a, 1'b0);
    wait_done(1'b0, 0, ok);
    chk("a_done_seen", {31'd0, ok}, 1);
    chk("a_total", total, 8);
    chk("a_size_err", {31'd0, size_err}, 0);
    chk("a_cdf_valid", {31'd0, cdf_valid}, 1);
    chk("a_overrun", {31'd0, overrun}, 0);
    @(negedge clk);
    chk("a_done_pulse", {31'd0, cdf_done}, 0);
    run_tbl("a", tbl_a);

    // Frame B: all pixels in bin 10, no carry-over from A.
    send_frame(px_b, 1'b0);
    wait_done(1'b0, 0, ok);
    chk("b_done_seen", {31'd0, ok}, 1);
    chk("b_total", total, 8);
    run_tbl("b", tbl_b);

    // Frame C: hold rd_addr=3 across the swap; old CDF[3]=0, new CDF[3]=3.
    @(posedge clk);
    #1 rd_addr = 8'd3;
    send_frame(px_c, 1'b0);
    wait_done(1'b1, 0, ok);
    chk("c_done_seen", {31'd0, ok}, 1);
    chk("c_hold_old_samples", mon_bad, 0);
    chk("c_swap_plus1_old", rd_data, 0);
    @(negedge clk);
    chk("c_swap_new", rd_data, 3);
    @(negedge clk);
    chk("c_swap_new_hold", rd_data, 3);

    // Frame D: six pixels with gaps in din_valid.
    send_frame(px_d, 1'b1);
    wait_done(1'b0, 0, ok);
    chk("d_done_seen", {31'd0, ok}, 1);
    chk("d_total", total, 6);
    chk("d_size_err", {31'd0, size_err}, 1);
    chk("d_cdf_valid", {31'd0, cdf_valid}, 1);
    run_tbl("d", tbl_d);

    // Frame E: next frame starts 20 cycles into blanking; its pixels are dropped.
    send_frame(px_a, 1'b0);
    tick(20);
    vsync = 1'b1;
    tick(2);
    for (int i = 0; i < 8; i++) begin
      din = 8'd9;
      din_valid = 1'b1;
      tick(1);
    end
    din_valid = 1'b0;
    wait_done(1'b0, 0, ok);
    chk("e_done_seen", {31'd0, ok}, 1);
    chk("e_overrun", {31'd0, overrun}, 1);
    chk("e_total", total, 8);
    run_tbl("e", tbl_e);

    // Reset in the middle of the collecting frame, then a clean frame.
    din = 8'd50;
    din_valid = 1'b1;
    tick(2);
    din_valid = 1'b0;
    rst_n = 1'b0;
    vsync = 1'b0;
    @(negedge clk);
    chk_reset_outs("rst2");
    tick(3);
    rst_n = 1'b1;
    tick(270);
    chk("f_pre_cdf_valid", {31'd0, cdf_valid}, 0);
    rd(8'd50, 0, "f_pre_rd_data");
    send_frame(px_f, 1'b0);
    wait_done(1'b0, 0, ok);
    chk("f_done_seen", {31'd0, ok}, 1);
    chk("f_total", total, 8);
    chk("f_size_err", {31'd0, size_err}, 0);
    chk("f_overrun", {31'd0, overrun}, 0);
    run_tbl("f", tbl_f);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hist_cdf_builder.md
HIST_CDF_BUILDER -- requirements
Module: hist_cdf_builder

Interface
REQ-001 SHALL have parameter DW, default 8, pixel width and log2 of the bin count.
REQ-002 SHALL have parameter IW, default 640, and parameter IH, default 512, the frame width and height in pixels.
REQ-003 SHALL have parameter TW, default 32, the count and CDF word width.
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 din_valid  in  1  pixel qualifier.
REQ-007 din  in  DW  pixel value, used as bin index.
REQ-008 vsync  in  1  high = active frame; falling edge = frame end.
REQ-009 rd_addr  in  DW  CDF read address, driven by the equalizer.
REQ-010 rd_data  out  TW  CDF of bin rd_addr from the published bank.
REQ-011 cdf_valid  out  1  high once at least one CDF has been published.
REQ-012 cdf_done  out  1  one-cycle pulse when a new CDF is published.
REQ-013 total  out  TW  final cumulative sum of the last published frame.
REQ-014 size_err  out  1  sticky; set when total != IW*IH.
REQ-015 overrun  out  1  sticky; set when pixels are dropped because a frame started during the sweep.

Function
REQ-016 The state machine SHALL have states IDLE, COLLECT, DRAIN, SWEEP and SWAP; reset state IDLE.
REQ-017 IDLE->COLLECT on vsync rising edge, with vsync registered once for edge detection.
REQ-018 COLLECT->DRAIN on vsync falling edge; DRAIN lasts 2 cycles; then ->SWEEP.
REQ-019 In COLLECT, each din_valid pixel SHALL increment count RAM[din] via a 2-stage read-modify-write: read in cycle n, write count+1 in cycle n+1.
REQ-020 Back-to-back pixels hitting the same bin SHALL forward the pending write value so that no increment is lost; a run of k equal pixels SHALL yield exactly +k.
REQ-021 Count SHALL saturate at 2^TW-1.
REQ-022 din_valid outside COLLECT SHALL be ignored.
REQ-023 SWEEP SHALL visit bins 0..2^DW-1, one per cycle.
REQ-024 During SWEEP, sum += count[i], the running sum SHALL be written to the shadow CDF bank[i], and count[i] SHALL be cleared to 0.
REQ-025 The running sum SHALL be TW bits and saturate.
REQ-026 SWAP (1 cycle) SHALL toggle the published bank, latch total, assert cdf_done, set cdf_valid, update size_err, and return to IDLE.
REQ-027 Sweep duration SHALL be 2^DW+1 cycles, DRAIN to SWAP; the required vertical blanking is >= 2^DW+4 cycles.
REQ-028 A vsync rising edge during DRAIN, SWEEP or SWAP SHALL NOT abort the sweep.
REQ-029 In that case, pixels of the new frame SHALL be dropped until the sweep ends, overrun SHALL be set, and the FSM SHALL enter COLLECT directly from SWAP if vsync is still high.
REQ-030 Read port latency SHALL be 1 cycle: rd_data at cycle n+1 = published bank[rd_addr at cycle n].
REQ-031 The read port is always enabled and never stalls.
REQ-032 Reads always see a complete frame's CDF; a read in the same cycle as SWAP SHALL return the old bank, and the following cycle the new bank.
REQ-033 Before the first publish, rd_data SHALL be 0 and cdf_valid SHALL be 0.
REQ-034 An empty frame (no valid pixels) SHALL publish an all-zero CDF with total 0, and SHALL set size_err.

Reset
REQ-035 Reset SHALL force: state IDLE, rd_data 0, cdf_valid 0, cdf_done 0, total 0, size_err 0, overrun 0, bank select 0, running sum 0.
REQ-036 RAM contents are not reset; after reset the block SHALL perform an initial clear sweep of count RAM (2^DW cycles, in IDLE) before accepting a frame.
REQ-037 During the initial clear sweep, a vsync rising edge SHALL be treated per REQ-029.
REQ-038 Reset mid-frame or mid-sweep SHALL discard all partial data and restart at REQ-036.

Structure
REQ-039 The shared image-processing package SHALL hold the DW/TW defaults, the FSM state encoding, and the blanking-requirement constant 2^DW+4.
REQ-040 One sub-module, hist_dpram, SHALL be used: a simple dual-port RAM (2^DW x TW, one write port, one registered read port).
REQ-041 hist_dpram SHALL be instantiated three times: count RAM and CDF banks 0 and 1.

Verification (bench parameters DW=8, IW=4, IH=2, TW=32)
REQ-042 Frame pixels {3,3,3,3,7,7,0,255} back-to-back -> after cdf_done: CDF[0]=1, CDF[2]=1, CDF[3]=5, CDF[6]=5, CDF[7]=7, CDF[254]=7, CDF[255]=8; total=8; size_err=0.
REQ-043 Two frames, the second all pixels =10 -> second CDF[9]=0, CDF[10]=8; count RAM cleared between frames, with no carry-over from frame 1.
REQ-044 Frame of 6 valid pixels with gaps in din_valid -> total=6, size_err=1; rd_data still valid.
REQ-045 vsync re-rises 20 cycles after its falling edge with pixels present -> overrun=1, the sweep completes, and CDF matches the first frame.
REQ-046 Continuous reads of rd_addr=3 across the SWAP cycle -> rd_data holds the old value through SWAP+1, then the new value; no intermediate value appears.
REQ-047 Assert rst_n low mid-COLLECT, then run a clean frame -> outputs are zero during reset, and the next CDF reflects only the clean frame.
